// File: rtl/uart_pkg.sv
// Shared types and helpers for the buffered UART echo block.
package uart_pkg;

    typedef enum logic [1:0] {
        PASS   = 2'b00,
        INVERT = 2'b01,
        HOLD   = 2'b10,
        DROP   = 2'b11
    } mode_e;

    // Core prescale: the cores time one bit as prescale*8 clocks.
    function automatic logic [15:0] uart_prescale(input int unsigned clk_freq,
                                                  input int unsigned baud);
        return 16'(clk_freq / (baud * 32'd8));
    endfunction

endpackage

// File: rtl/uart_rx.sv
// AXI-stream UART receiver, 8N1 style framing, one bit = prescale*8 clocks.
module uart_rx #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    input  logic                  rxd,
    input  logic [15:0]           prescale
);
    localparam int unsigned BitW = $clog2(DATA_WIDTH + 2);

    logic                  r_rxd_meta;
    logic                  r_rxd;
    logic                  r_busy;
    logic [18:0]           r_cnt;
    logic [BitW-1:0]       r_bits;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_valid;
    logic [18:0]           w_bit_cycles;

    assign w_bit_cycles = {prescale, 3'b000};

    // Sample mid-bit: half a bit after the start edge, then every full bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rxd_meta <= 1'b1;
            r_rxd      <= 1'b1;
            r_busy     <= 1'b0;
            r_cnt      <= '0;
            r_bits     <= '0;
            r_shift    <= '0;
            r_data     <= '0;
            r_valid    <= 1'b0;
        end else begin
            r_rxd_meta <= rxd;
            r_rxd      <= r_rxd_meta;
            if (m_axis_tready) r_valid <= 1'b0;
            if (!r_busy) begin
                if (!r_rxd) begin
                    r_busy <= 1'b1;
                    r_bits <= BitW'(DATA_WIDTH + 1);
                    r_cnt  <= {1'b0, prescale, 2'b00} - 19'd1;
                end
            end else if (r_cnt != '0) begin
                r_cnt <= r_cnt - 19'd1;
            end else begin
                r_cnt <= w_bit_cycles - 19'd1;
                if (r_bits == BitW'(DATA_WIDTH + 1)) begin
                    if (r_rxd) r_busy <= 1'b0;
                    else       r_bits <= r_bits - BitW'(1);
                end else if (r_bits != '0) begin
                    r_shift <= {r_rxd, r_shift[DATA_WIDTH-1:1]};
                    r_bits  <= r_bits - BitW'(1);
                end else begin
                    r_busy <= 1'b0;
                    if (r_rxd) begin
                        r_data  <= r_shift;
                        r_valid <= 1'b1;
                    end
                end
            end
        end
    end

    assign m_axis_tdata  = r_data;
    assign m_axis_tvalid = r_valid;

endmodule

// File: rtl/uart_sync_fifo.sv
// First-word-fall-through synchronous FIFO with an explicit occupancy count.
module uart_sync_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 16
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_push_valid,
    output logic                       o_push_ready_c,
    input  logic [Width-1:0]           i_push_data,
    output logic                       o_pop_valid,
    input  logic                       i_pop_ready,
    output logic [Width-1:0]           o_pop_data_c,
    output logic [$clog2(Depth+1)-1:0] o_count,
    output logic                       o_full,
    output logic                       o_empty
);
    localparam int unsigned CntW = $clog2(Depth + 1);
    localparam int unsigned PtrW = $clog2(Depth);

    logic [Width-1:0] r_mem [Depth];
    logic [PtrW-1:0]  r_wr_ptr;
    logic [PtrW-1:0]  r_rd_ptr;
    logic [CntW-1:0]  r_count;
    logic [CntW-1:0]  w_count_next;
    logic             r_full;
    logic             r_empty;
    logic             w_push;
    logic             w_pop;

    // A full FIFO still accepts a word when the head leaves in the same cycle.
    assign o_push_ready_c = ~r_full | i_pop_ready;
    assign w_push         = i_push_valid & o_push_ready_c;
    assign w_pop          = ~r_empty & i_pop_ready;

    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + CntW'(1);
        end else if (!w_push && w_pop) begin
            w_count_next = r_count - CntW'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PtrW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PtrW'(1);
            r_count <= w_count_next;
            r_full  <= (w_count_next == CntW'(Depth));
            r_empty <= (w_count_next == '0);
        end
    end

    // Storage needs no reset; validity is carried by the count.
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_push_data;
    end

    assign o_pop_data_c = r_mem[r_rd_ptr];
    assign o_pop_valid  = ~r_empty;
    assign o_count      = r_count;
    assign o_full       = r_full;
    assign o_empty      = r_empty;

endmodule

// File: rtl/uart_tx.sv
// AXI-stream UART transmitter, 8N1 style framing, one bit = prescale*8 clocks.
module uart_tx #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic                  txd,
    input  logic [15:0]           prescale
);
    localparam int unsigned BitW = $clog2(DATA_WIDTH + 2);

    logic [DATA_WIDTH:0] r_shift;
    logic [18:0]         r_cnt;
    logic [BitW-1:0]     r_bits;
    logic                r_busy;
    logic                r_txd;
    logic [18:0]         w_bit_cycles;

    assign w_bit_cycles = {prescale, 3'b000};

    // Start bit goes out on accept; data and stop bit follow from the shifter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift <= '0;
            r_cnt   <= '0;
            r_bits  <= '0;
            r_busy  <= 1'b0;
            r_txd   <= 1'b1;
        end else if (!r_busy) begin
            if (s_axis_tvalid) begin
                r_busy  <= 1'b1;
                r_txd   <= 1'b0;
                r_shift <= {1'b1, s_axis_tdata};
                r_bits  <= BitW'(DATA_WIDTH + 1);
                r_cnt   <= w_bit_cycles - 19'd1;
            end
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 19'd1;
        end else if (r_bits != '0) begin
            r_txd   <= r_shift[0];
            r_shift <= {1'b0, r_shift[DATA_WIDTH:1]};
            r_bits  <= r_bits - BitW'(1);
            r_cnt   <= w_bit_cycles - 19'd1;
        end else begin
            r_busy <= 1'b0;
        end
    end

    assign s_axis_tready = ~r_busy;
    assign txd           = r_txd;

endmodule

// File: rtl/uart_echo_buffered.sv
// UART echo: rx words are transformed, queued in a FIFO and retransmitted,
// with hold/drop modes and overflow accounting.
module uart_echo_buffered
    import uart_pkg::*;
#(
    parameter int unsigned ClkFreq   = 32256000,
    parameter int unsigned BaudRate  = 115200,
    parameter int unsigned DataWidth = 8,
    parameter int unsigned FifoDepth = 16
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           rx_i,
    output logic                           tx_o,
    input  logic [1:0]                     mode_i,
    output logic [$clog2(FifoDepth+1)-1:0] fifo_count_o,
    output logic                           overflow_o,
    output logic [15:0]                    drop_count_o
);
    localparam int unsigned CntW     = $clog2(FifoDepth + 1);
    localparam logic [15:0] Prescale = uart_prescale(ClkFreq, BaudRate);

    logic [1:0]           r_mode_meta;
    mode_e                r_mode_q;
    logic                 r_overflow;
    logic [15:0]          r_drop_count;

    logic                 w_core_rst;
    logic [DataWidth-1:0] w_rx_data;
    logic                 w_rx_valid;
    logic [DataWidth-1:0] w_push_data;
    logic                 w_push_valid;
    logic                 w_push_ready_c;
    logic                 w_lost;
    logic [DataWidth-1:0] w_fifo_data;
    logic                 w_fifo_valid;
    logic                 w_fifo_full;
    logic                 w_fifo_empty;
    logic [CntW-1:0]      w_fifo_count;
    logic                 w_tx_valid;
    logic                 w_tx_ready;

    assign w_core_rst = ~rst_ni;

    // Mode switches are asynchronous; two flops before anything sees them.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_mode_meta <= 2'b00;
            r_mode_q    <= PASS;
        end else begin
            r_mode_meta <= mode_i;
            r_mode_q    <= mode_e'(r_mode_meta);
        end
    end

    uart_rx #(
        .DATA_WIDTH(DataWidth)
    ) u_rx (
        .clk          (clk_i),
        .rst          (w_core_rst),
        .m_axis_tdata (w_rx_data),
        .m_axis_tvalid(w_rx_valid),
        .m_axis_tready(1'b1),
        .rxd          (rx_i),
        .prescale     (Prescale)
    );

    // Transform at write time so queued words keep the mode they arrived under.
    assign w_push_data  = (r_mode_q == INVERT) ? ~w_rx_data : w_rx_data;
    assign w_push_valid = w_rx_valid & (r_mode_q != DROP);
    assign w_lost       = w_push_valid & ~w_push_ready_c;

    uart_sync_fifo #(
        .Width(DataWidth),
        .Depth(FifoDepth)
    ) u_fifo (
        .i_clk         (clk_i),
        .i_rst_n       (rst_ni),
        .i_push_valid  (w_push_valid),
        .o_push_ready_c(w_push_ready_c),
        .i_push_data   (w_push_data),
        .o_pop_valid   (w_fifo_valid),
        .i_pop_ready   (w_tx_ready & (r_mode_q != HOLD)),
        .o_pop_data_c  (w_fifo_data),
        .o_count       (w_fifo_count),
        .o_full        (w_fifo_full),
        .o_empty       (w_fifo_empty)
    );

    assign w_tx_valid = w_fifo_valid & (r_mode_q != HOLD);

    uart_tx #(
        .DATA_WIDTH(DataWidth)
    ) u_tx (
        .clk          (clk_i),
        .rst          (w_core_rst),
        .s_axis_tdata (w_fifo_data),
        .s_axis_tvalid(w_tx_valid),
        .s_axis_tready(w_tx_ready),
        .txd          (tx_o),
        .prescale     (Prescale)
    );

    // Sticky overflow flag and saturating loss counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else if (w_lost) begin
            r_overflow <= 1'b1;
            if (r_drop_count != 16'hFFFF) r_drop_count <= r_drop_count + 16'd1;
        end
    end

    a_full_not_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
        w_fifo_full |-> !w_fifo_empty);

    assign fifo_count_o = w_fifo_count;
    assign overflow_o   = r_overflow;
    assign drop_count_o = r_drop_count;

endmodule

// File: tb/tb_uart_echo_buffered.sv
// Directed bench: drives rx_i as a UART line, decodes tx_o, checks status outputs.
module tb_uart_echo_buffered;
    import uart_pkg::*;

    localparam int unsigned ClkFreq   = 3686400;
    localparam int unsigned BaudRate  = 115200;
    localparam int unsigned FifoDepth = 16;
    localparam int unsigned CntW      = $clog2(FifoDepth + 1);
    localparam int          Bit       = 32;
    localparam int          Frame     = 10 * Bit;

    logic            clk = 1'b0;
    logic            rst_ni;
    logic            rx_i;
    logic            tx_o;
    logic [1:0]      mode_i;
    logic [CntW-1:0] fifo_count;
    logic            overflow;
    logic [15:0]     drop_count;

    int         n_checks = 0;
    int         n_pass   = 0;
    int         tx_low   = 0;
    int         peak     = 0;
    logic [7:0] tx_q[$];

    always #5 clk = ~clk;

    uart_echo_buffered #(
        .ClkFreq  (ClkFreq),
        .BaudRate (BaudRate),
        .DataWidth(8),
        .FifoDepth(FifoDepth)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .rx_i        (rx_i),
        .tx_o        (tx_o),
        .mode_i      (mode_i),
        .fifo_count_o(fifo_count),
        .overflow_o  (overflow),
        .drop_count_o(drop_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_i = 1'b0;
        repeat (Bit) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_i = b[i];
            repeat (Bit) @(negedge clk);
        end
        rx_i = 1'b1;
        repeat (Bit) @(negedge clk);
    endtask

    task automatic expect_word(input string tag, input logic [7:0] exp, input int budget);
        int          c;
        logic [31:0] got;
        c = 0;
        while (tx_q.size() == 0 && c < budget) begin
            @(negedge clk);
            c++;
        end
        got = 32'hDEAD_0000;
        if (tx_q.size() != 0) got = 32'(tx_q.pop_front());
        check(tag, got, 32'(exp));
    endtask

    // Line activity and occupancy peak, sampled on the falling clock edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_ni === 1'b1 && tx_o === 1'b0) tx_low++;
            if (int'(fifo_count) > peak) peak = int'(fifo_count);
        end
    end

    // Serial decoder for tx_o; frames overlapping reset are discarded.
    initial begin
        logic [7:0] b;
        logic       bad;
        forever begin
            @(negedge tx_o);
            b   = '0;
            bad = !rst_ni;
            repeat (Bit / 2) @(negedge clk);
            bad = bad | !rst_ni | tx_o;
            for (int i = 0; i < 8; i++) begin
                repeat (Bit) @(negedge clk);
                b[i] = tx_o;
                bad  = bad | !rst_ni;
            end
            repeat (Bit) @(negedge clk);
            bad = bad | !rst_ni | !tx_o;
            if (!bad) tx_q.push_back(b);
        end
    end

    initial begin
        rst_ni = 1'b0;
        rx_i   = 1'b1;
        mode_i = PASS;
        repeat (4) @(negedge clk);
        check("reset_tx", 32'(tx_o), 32'd1);
        check("reset_count", 32'(fifo_count), 32'd0);
        check("reset_overflow", 32'(overflow), 32'd0);
        check("reset_drops", 32'(drop_count), 32'd0);
        rst_ni = 1'b1;
        repeat (8) @(negedge clk);

        // PASS
        peak = 0;
        send_byte(8'h41);
        expect_word("pass_word", 8'h41, 2 * Frame);
        check("pass_peak", 32'(peak), 32'd1);
        repeat (2 * Bit) @(negedge clk);
        check("pass_count", 32'(fifo_count), 32'd0);

        // INVERT
        mode_i = INVERT;
        repeat (8) @(negedge clk);
        send_byte(8'h0F);
        send_byte(8'hA5);
        expect_word("invert_word0", 8'hF0, 2 * Frame);
        expect_word("invert_word1", 8'h5A, 2 * Frame);

        // HOLD: fill, then overflow by one
        mode_i = HOLD;
        repeat (2 * Bit) @(negedge clk);
        tx_low = 0;
        for (int i = 0; i < 16; i++) send_byte(8'(i));
        repeat (4) @(negedge clk);
        check("hold_count", 32'(fifo_count), 32'd16);
        check("hold_tx_idle", 32'(tx_low), 32'd0);
        check("hold_no_words", 32'(tx_q.size()), 32'd0);
        check("hold_no_overflow", 32'(overflow), 32'd0);
        send_byte(8'hAA);
        repeat (4) @(negedge clk);
        check("hold_overflow", 32'(overflow), 32'd1);
        check("hold_drops", 32'(drop_count), 32'd1);
        check("hold_full_count", 32'(fifo_count), 32'd16);
        mode_i = PASS;
        for (int i = 0; i < 16; i++)
            expect_word($sformatf("release_word%0d", i), 8'(i), 2 * Frame);
        repeat (2 * Frame) @(negedge clk);
        check("release_no_aa", 32'(tx_q.size()), 32'd0);
        check("release_count", 32'(fifo_count), 32'd0);

        // DROP
        mode_i = DROP;
        repeat (8) @(negedge clk);
        tx_low = 0;
        send_byte(8'h55);
        repeat (Frame) @(negedge clk);
        check("drop_no_words", 32'(tx_q.size()), 32'd0);
        check("drop_tx_idle", 32'(tx_low), 32'd0);
        check("drop_count", 32'(fifo_count), 32'd0);
        check("drop_counter_kept", 32'(drop_count), 32'd1);

        // Mode switch mid-stream
        mode_i = HOLD;
        repeat (8) @(negedge clk);
        send_byte(8'h01);
        send_byte(8'h02);
        repeat (4) @(negedge clk);
        check("switch_queued", 32'(fifo_count), 32'd2);
        mode_i = INVERT;
        repeat (8) @(negedge clk);
        send_byte(8'h03);
        expect_word("switch_word0", 8'h01, 3 * Frame);
        expect_word("switch_word1", 8'h02, 3 * Frame);
        expect_word("switch_word2", 8'hFC, 3 * Frame);

        // Reset during a tx frame with three words still queued
        mode_i = HOLD;
        repeat (Frame) @(negedge clk);
        send_byte(8'h41);
        send_byte(8'h42);
        send_byte(8'h43);
        send_byte(8'h44);
        mode_i = PASS;
        repeat (3 * Bit) @(negedge clk);
        check("prereset_count", 32'(fifo_count), 32'd3);
        rst_ni = 1'b0;
        @(negedge clk);
        check("midreset_tx", 32'(tx_o), 32'd1);
        check("midreset_count", 32'(fifo_count), 32'd0);
        check("midreset_overflow", 32'(overflow), 32'd0);
        check("midreset_drops", 32'(drop_count), 32'd0);
        repeat (2 * Bit) @(negedge clk);
        rst_ni = 1'b1;
        tx_low = 0;
        repeat (3 * Frame) @(negedge clk);
        check("postreset_tx_idle", 32'(tx_low), 32'd0);
        check("postreset_no_words", 32'(tx_q.size()), 32'd0);
        send_byte(8'h66);
        expect_word("postreset_word", 8'h66, 2 * Frame);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_echo_buffered.md
# uart_echo_buffered

Parametrised successor to the direct rx→tx UART loopback: received words pass through a configurable-depth FIFO and a runtime-selectable transform stage before retransmission. It adds hold/drop modes, overflow accounting and occupancy status. It sits at the board top between the `rx_i`/`tx_o` pins and drives the existing third-party `uart_rx`/`uart_tx` AXI-stream cores. It is the staging point for the ALU datapath that replaces the transform stage later.

## Interface
- `ClkFreq`, 32256000: `clk_i` frequency in Hz.
- `BaudRate`, 115200: line rate.
- `DataWidth`, 8: UART data bits per frame; passed to both UART cores.
- `FifoDepth`, 16: FIFO entries; power of two, ≥2.
- `clk_i` in 1: sole clock.
- `rst_ni` in 1: asynchronous, active-low reset.
- `rx_i` in 1: serial input, idle high.
- `tx_o` out 1: serial output, idle high.
- `mode_i` in 2: 00 PASS, 01 INVERT, 10 HOLD, 11 DROP; asynchronous (switches).
- `fifo_count_o` out `$clog2(FifoDepth+1)`: current occupancy.
- `overflow_o` out 1: sticky; set on first word lost to a full FIFO.
- `drop_count_o` out 16: saturating count of words lost to a full FIFO.

## Operation
- Prescale constant: `16'(ClkFreq/(BaudRate*8))`; 35 at defaults. Drives both cores.
- Core reset input is `~rst_ni`.
- `mode_i` passes through a two-flop synchroniser, giving `mode_q`. All logic uses `mode_q`.
- `uart_rx` `m_axis_tready` is tied 1, so the core never overruns. Each rx valid beat is one received word.
- Write path, per rx beat:
  - DROP: word discarded. No counters change.
  - FIFO full and no pop this cycle: word discarded; `overflow_o` set to 1; `drop_count_o` incremented, saturating at 16'hFFFF.
  - Otherwise: push the transformed word.
- Transform is applied at write time, so mode changes do not alter words already queued:
  - PASS, HOLD: word unchanged.
  - INVERT: bitwise NOT of the word.
- FIFO is first-word-fall-through.
  - `uart_tx` `s_axis_tvalid` = !empty && `mode_q` != HOLD.
  - Pop on tvalid && tready.
- HOLD: words keep accumulating and tx stays idle. Leaving HOLD releases the queued words in arrival order.
- A tx frame already in progress always completes, whatever the mode change.
- Full with simultaneous push and pop: both occur, count unchanged, no drop.
- Empty with push: word is visible on the tx interface the next cycle. No same-cycle bypass.
- Pointers wrap modulo `FifoDepth`. The count is tracked separately so full and empty are unambiguous.

## Timing
- Reset values: `tx_o`=1, `fifo_count_o`=0, `overflow_o`=0, `drop_count_o`=0, FIFO pointers 0, `mode_q`=PASS.
- Reset asserted mid-frame:
  - FIFO and status clear asynchronously.
  - `tx_o` returns high by the first `clk_i` edge during reset.
  - Partial rx/tx frames are abandoned. No word is emitted after reset release.
- rx beat in cycle N → `fifo_count_o` updated and tx tvalid high in cycle N+1 (empty FIFO, non-HOLD).
- Mode change on the pins takes effect 2–3 cycles later.
- Sustained throughput: one word per frame time, with no loss, when rx and tx run at the same baud.

## Structure
- Package `uart_pkg` holds:
  - `mode_e` enum {PASS, INVERT, HOLD, DROP}, 2-bit.
  - Function `uart_prescale(clk_freq, baud)` returning 16 bits.
- Sub-module `uart_sync_fifo`:
  - Parameters `Width`, `Depth`.
  - Interface: push/pop valid-ready, `count_o`, full/empty.
  - Same clock and reset as this block.
- Top contains: synchroniser, transform, drop logic, status registers, and the core instances.

## Test plan
Bit period is 280 clocks at defaults.
- PASS: send 0x41 → `tx_o` emits 0x41 framed 8N1; `fifo_count_o` peaks at 1 and returns to 0.
- INVERT: send 0x0F, 0xA5 → tx emits 0xF0, 0x5A in order.
- HOLD: send 0x00..0x0F → `tx_o` stays high and `fifo_count_o`=16.
  - Then send 0xAA → `overflow_o`=1, `drop_count_o`=1.
  - Then switch to PASS → tx emits 0x00..0x0F in order; 0xAA never appears.
- DROP: send 0x55 → no tx activity; `fifo_count_o`=0; `drop_count_o` unchanged.
- Mode switch mid-stream: queue 0x01, 0x02 in HOLD, switch to INVERT, send 0x03 → tx emits 0x01, 0x02, 0xFC.
- Reset mid-tx: assert `rst_ni`=0 during the tx frame of 0x41 with 3 words queued.
  - During reset: `tx_o`=1, count=0, `overflow_o`=0.
  - After release: no output until a new word is received.
